// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the AXI-lite load/store unit
//
// Purpose: FSM state encoding, error codes, RISC-V load/store funct3 codes,
//          AXI response codes and the response-check helper.
// Ports:   none (package).
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } lsu_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_BUS      = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;

    // EXOKAY is only tolerated when the slave side is known to use exclusives.
    function automatic logic resp_bad(input logic [1:0] resp, input bit okay_only);
        if (okay_only) begin
            return resp != OKAY;
        end
        return (resp != OKAY) && (resp != EXOKAY);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational size decode, alignment check and lane steering
//
// Purpose: decodes funct3 into an access size, flags illegal sizes and
//          misaligned addresses, right-justifies and extends load data, and
//          lane-shifts store data with its byte strobes.
// Ports:   is_load/is_store/funct3/addr_lo - op being decoded
//          rdata      - raw bus read data
//          wdata      - LSB-aligned store data
//          illegal    - funct3 not a legal size for this op and DATA_W
//          misaligned - address not naturally aligned for the size
//          load_data  - shifted and sign/zero-extended load result
//          store_data - store data moved to its byte lanes
//          store_strb - byte strobes matching store_data
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                is_load,
    input  logic                is_store,
    input  logic [2:0]          funct3,
    input  logic [2:0]          addr_lo,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [DATA_W-1:0]   wdata,
    output logic                illegal,
    output logic                misaligned,
    output logic [DATA_W-1:0]   load_data,
    output logic [DATA_W-1:0]   store_data,
    output logic [DATA_W/8-1:0] store_strb
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam bit HAS_D  = (DATA_W == 64);

    logic [OFF_W-1:0]  off;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;
    logic [7:0]        strb_base;

    assign off = addr_lo[OFF_W-1:0];

    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        shifted    = rdata >> {off, 3'b000};
        mask       = '1;
        sign_bit   = 1'b0;
        strb_base  = 8'hff;

        if (is_load) begin
            case (funct3)
                LB, LH, LW, LBU, LHU: illegal = 1'b0;
                LD, LWU:              illegal = !HAS_D;
                default:              illegal = 1'b1;
            endcase
        end else if (is_store) begin
            illegal = funct3[2] || ((funct3[1:0] == 2'b11) && !HAS_D);
        end

        case (funct3[1:0])
            2'b00: begin
                mask      = DATA_W'(8'hff);
                sign_bit  = shifted[7];
                strb_base = 8'h01;
            end
            2'b01: begin
                misaligned = addr_lo[0];
                mask       = DATA_W'(16'hffff);
                sign_bit   = shifted[15];
                strb_base  = 8'h03;
            end
            2'b10: begin
                misaligned = |addr_lo[1:0];
                mask       = DATA_W'(32'hffff_ffff);
                sign_bit   = shifted[31];
                strb_base  = 8'h0f;
            end
            default: begin
                misaligned = |addr_lo;
                mask       = '1;
                sign_bit   = 1'b0;
                strb_base  = 8'hff;
            end
        endcase
    end

    // funct3[2] marks the unsigned load variants; bits above the size fill
    // with the sign bit only for the signed ones.
    assign load_data  = (shifted & mask) | ((!funct3[2] && sign_bit) ? ~mask : '0);
    assign store_data = wdata << {off, 3'b000};
    assign store_strb = STRB_W'(strb_base) << off;

endmodule

// File: rtl/lsu_axil_fsm.sv
// rtl/lsu_axil_fsm.sv - load/store unit running one AXI-lite transaction per op
//
// Purpose: accepts one decoded memory op per in_valid/in_ready handshake,
//          traps illegal sizes and misalignment, issues a single AXI-lite
//          read or write with registered outputs, checks the response and
//          presents extended load data plus error status downstream.
// Ports:   clk, rst_n (async, active-low)
//          in_*       - upstream op: valid/ready, load/store, funct3, addr, wdata
//          out_*      - result: valid/ready, rdata, err, err_code
//          ar*/r*     - AXI-lite read address / read data channels
//          aw*/w*/b*  - AXI-lite write address / write data / response channels
module lsu_axil_fsm
    import lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter bit OKAY_ONLY = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_load,
    input  logic                in_store,
    input  logic [2:0]          in_funct3,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic [1:0]          out_err_code,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    input  logic [DATA_W-1:0]   rdata,
    input  logic [1:0]          rresp,
    input  logic                rvalid,
    output logic                rready,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    input  logic [1:0]          bresp,
    input  logic                bvalid,
    output logic                bready
);

    localparam int STRB_W = DATA_W / 8;

    lsu_state_e          state_q, state_n;
    logic [ADDR_W-1:0]   addr_q, addr_n;
    logic [2:0]          funct3_q, funct3_n;
    logic                arvalid_q, arvalid_n;
    logic                rready_q, rready_n;
    logic                awvalid_q, awvalid_n;
    logic                wvalid_q, wvalid_n;
    logic                bready_q, bready_n;
    logic [DATA_W-1:0]   wdata_q, wdata_n;
    logic [STRB_W-1:0]   wstrb_q, wstrb_n;
    logic                out_valid_q, out_valid_n;
    logic [DATA_W-1:0]   rdata_q, rdata_n;
    logic                err_q, err_n;
    logic [1:0]          code_q, code_n;

    logic                idle;
    logic [2:0]          al_funct3;
    logic [2:0]          al_addr;
    logic                al_illegal;
    logic                al_misaligned;
    logic [DATA_W-1:0]   al_load_data;
    logic [DATA_W-1:0]   al_store_data;
    logic [STRB_W-1:0]   al_store_strb;
    logic                bad_resp;

    // One aligner serves both decode at accept (live inputs) and load
    // extension in RD_DATA (latched op), since those never overlap.
    assign idle      = (state_q == S_IDLE);
    assign al_funct3 = idle ? in_funct3 : funct3_q;
    assign al_addr   = idle ? in_addr[2:0] : addr_q[2:0];

    lsu_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .is_load    (in_load),
        .is_store   (in_store),
        .funct3     (al_funct3),
        .addr_lo    (al_addr),
        .rdata      (rdata),
        .wdata      (in_wdata),
        .illegal    (al_illegal),
        .misaligned (al_misaligned),
        .load_data  (al_load_data),
        .store_data (al_store_data),
        .store_strb (al_store_strb)
    );

    assign bad_resp = resp_bad((state_q == S_RD_DATA) ? rresp : bresp, OKAY_ONLY);

    always_comb begin
        state_n     = state_q;
        addr_n      = addr_q;
        funct3_n    = funct3_q;
        arvalid_n   = arvalid_q;
        rready_n    = rready_q;
        awvalid_n   = awvalid_q;
        wvalid_n    = wvalid_q;
        bready_n    = bready_q;
        wdata_n     = wdata_q;
        wstrb_n     = wstrb_q;
        out_valid_n = out_valid_q;
        rdata_n     = rdata_q;
        err_n       = err_q;
        code_n      = code_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    addr_n   = in_addr;
                    funct3_n = in_funct3;
                    rdata_n  = '0;
                    err_n    = 1'b0;
                    code_n   = ERR_NONE;
                    if (!in_load && !in_store) begin
                        state_n     = S_DONE;
                        out_valid_n = 1'b1;
                    end else if (al_illegal) begin
                        state_n     = S_DONE;
                        out_valid_n = 1'b1;
                        err_n       = 1'b1;
                        code_n      = ERR_SIZE;
                    end else if (al_misaligned) begin
                        state_n     = S_DONE;
                        out_valid_n = 1'b1;
                        err_n       = 1'b1;
                        code_n      = ERR_MISALIGN;
                    end else if (in_load) begin
                        state_n   = S_RD_ADDR;
                        arvalid_n = 1'b1;
                    end else begin
                        state_n   = S_WR_REQ;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        wdata_n   = al_store_data;
                        wstrb_n   = al_store_strb;
                    end
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    rready_n    = 1'b0;
                    rdata_n     = al_load_data;
                    err_n       = bad_resp;
                    code_n      = bad_resp ? ERR_BUS : ERR_NONE;
                    out_valid_n = 1'b1;
                    state_n     = S_DONE;
                end
            end
            S_WR_REQ: begin
                // Each channel drops after its own handshake; a low valid here
                // means that channel already completed.
                awvalid_n = awvalid_q && !awready;
                wvalid_n  = wvalid_q && !wready;
                if (!awvalid_n && !wvalid_n) begin
                    bready_n = 1'b1;
                    state_n  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    bready_n    = 1'b0;
                    err_n       = bad_resp;
                    code_n      = bad_resp ? ERR_BUS : ERR_NONE;
                    out_valid_n = 1'b1;
                    state_n     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            funct3_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            out_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            code_q      <= ERR_NONE;
        end else begin
            state_q     <= state_n;
            addr_q      <= addr_n;
            funct3_q    <= funct3_n;
            arvalid_q   <= arvalid_n;
            rready_q    <= rready_n;
            awvalid_q   <= awvalid_n;
            wvalid_q    <= wvalid_n;
            bready_q    <= bready_n;
            wdata_q     <= wdata_n;
            wstrb_q     <= wstrb_n;
            out_valid_q <= out_valid_n;
            rdata_q     <= rdata_n;
            err_q       <= err_n;
            code_q      <= code_n;
        end
    end

    assign in_ready     = idle;
    assign araddr       = addr_q;
    assign awaddr       = addr_q;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign awvalid      = awvalid_q;
    assign wvalid       = wvalid_q;
    assign bready       = bready_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign out_valid    = out_valid_q;
    assign out_rdata    = rdata_q;
    assign out_err      = err_q;
    assign out_err_code = code_q;

endmodule

// File: tb/tb_lsu_axil_fsm.sv
// tb/tb_lsu_axil_fsm.sv - directed self-checking bench for lsu_axil_fsm
module tb_lsu_axil_fsm;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // 32-bit ops, shared by the OKAY_ONLY=1 (a_) and OKAY_ONLY=0 (b_) instances
    logic        in_valid, in_load, in_store, out_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata, rdata;
    logic        arready, rvalid, awready, wready, bvalid;
    logic [1:0]  rresp, bresp;

    logic        a_in_ready, a_out_valid, a_out_err, a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready;
    logic [1:0]  a_code;
    logic [31:0] a_out_rdata, a_araddr, a_awaddr, a_wdata;
    logic [3:0]  a_wstrb;

    logic        b_in_ready, b_out_valid, b_out_err, b_arvalid, b_rready, b_awvalid, b_wvalid, b_bready;
    logic [1:0]  b_code;
    logic [31:0] b_out_rdata, b_araddr, b_awaddr, b_wdata;
    logic [3:0]  b_wstrb;

    // 64-bit instance
    logic        d_in_valid, d_in_load, d_in_store, d_out_ready;
    logic [2:0]  d_funct3;
    logic [31:0] d_addr;
    logic [63:0] d_in_wdata, d_rdata;
    logic        d_arready, d_rvalid, d_awready, d_wready, d_bvalid;
    logic [1:0]  d_rresp, d_bresp;
    logic        d_in_ready, d_out_valid, d_out_err, d_arvalid, d_rready, d_awvalid, d_wvalid, d_bready;
    logic [1:0]  d_code;
    logic [63:0] d_out_rdata, d_wdata;
    logic [31:0] d_araddr, d_awaddr;
    logic [7:0]  d_wstrb;

    lsu_axil_fsm #(.ADDR_W(32), .DATA_W(32), .OKAY_ONLY(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_rdata(a_out_rdata),
        .out_err(a_out_err), .out_err_code(a_code),
        .araddr(a_araddr), .arvalid(a_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(a_rready),
        .awaddr(a_awaddr), .awvalid(a_awvalid), .awready(awready),
        .wdata(a_wdata), .wstrb(a_wstrb), .wvalid(a_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(a_bready)
    );

    lsu_axil_fsm #(.ADDR_W(32), .DATA_W(32), .OKAY_ONLY(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_rdata(b_out_rdata),
        .out_err(b_out_err), .out_err_code(b_code),
        .araddr(b_araddr), .arvalid(b_arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(b_rready),
        .awaddr(b_awaddr), .awvalid(b_awvalid), .awready(awready),
        .wdata(b_wdata), .wstrb(b_wstrb), .wvalid(b_wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(b_bready)
    );

    lsu_axil_fsm #(.ADDR_W(32), .DATA_W(64), .OKAY_ONLY(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n),
        .in_valid(d_in_valid), .in_ready(d_in_ready), .in_load(d_in_load), .in_store(d_in_store),
        .in_funct3(d_funct3), .in_addr(d_addr), .in_wdata(d_in_wdata),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .out_rdata(d_out_rdata),
        .out_err(d_out_err), .out_err_code(d_code),
        .araddr(d_araddr), .arvalid(d_arvalid), .arready(d_arready),
        .rdata(d_rdata), .rresp(d_rresp), .rvalid(d_rvalid), .rready(d_rready),
        .awaddr(d_awaddr), .awvalid(d_awvalid), .awready(d_awready),
        .wdata(d_wdata), .wstrb(d_wstrb), .wvalid(d_wvalid), .wready(d_wready),
        .bresp(d_bresp), .bvalid(d_bvalid), .bready(d_bready)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        in_valid  = 1'b1;
        in_load   = ld;
        in_store  = st;
        in_funct3 = f3;
        in_addr   = addr;
        in_wdata  = wd;
        @(negedge clk);
        in_valid  = 1'b0;
        in_load   = 1'b0;
        in_store  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_load = 0; in_store = 0; out_ready = 0; in_funct3 = 0;
        in_addr = 0; in_wdata = 0; rdata = 0; arready = 0; rvalid = 0;
        awready = 0; wready = 0; bvalid = 0; rresp = 0; bresp = 0;
        d_in_valid = 0; d_in_load = 0; d_in_store = 0; d_out_ready = 0; d_funct3 = 0;
        d_addr = 0; d_in_wdata = 0; d_rdata = 0; d_arready = 0; d_rvalid = 0;
        d_awready = 0; d_wready = 0; d_bvalid = 0; d_rresp = 0; d_bresp = 0;

        repeat (2) @(negedge clk);
        chk("rst_valids", {a_arvalid, a_awvalid, a_wvalid, a_rready, a_bready, a_out_valid}, 0);
        chk("rst_outs", {a_out_rdata, a_out_err, a_code}, 0);
        chk("rst_valids_64", {d_arvalid, d_awvalid, d_wvalid, d_rready, d_bready, d_out_valid, d_out_err}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", a_in_ready, 1);

        // LB sign-extend, zero-wait slave, then 5 cycles of backpressure
        issue(1'b1, 1'b0, LB, 32'h8000_0003, 32'h0);
        chk("lb_t1_ar", {a_arvalid, a_out_valid, a_in_ready}, 3'b100);
        chk("lb_araddr", a_araddr, 32'h8000_0003);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("lb_t2_r", {a_arvalid, a_rready, a_out_valid}, 3'b010);
        rvalid = 1'b1; rdata = 32'h80FF_1234; rresp = OKAY;
        @(negedge clk);
        rvalid = 1'b0;
        chk("lb_t3_out", {a_out_valid, a_rready, a_out_err, a_code}, {1'b1, 1'b0, 1'b0, 2'b00});
        chk("lb_rdata", a_out_rdata, 32'hFFFF_FF80);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold", {a_out_valid, a_in_ready, a_out_err, a_out_rdata}, {1'b1, 1'b0, 1'b0, 32'hFFFF_FF80});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("lb_release", {a_out_valid, a_in_ready}, 2'b01);

        // SH with W accepted two cycles ahead of AW
        issue(1'b0, 1'b1, SH, 32'h8000_0002, 32'h0000_ABCD);
        chk("sh_req", {a_awvalid, a_wvalid}, 2'b11);
        chk("sh_wdata", a_wdata, 32'hABCD_0000);
        chk("sh_wstrb", a_wstrb, 4'b1100);
        chk("sh_awaddr", a_awaddr, 32'h8000_0002);
        wready = 1'b1;
        @(negedge clk);
        wready = 1'b0;
        chk("sh_w_done", {a_awvalid, a_wvalid, a_bready}, 3'b100);
        @(negedge clk);
        chk("sh_aw_wait", {a_awvalid, a_wvalid, a_bready}, 3'b100);
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        chk("sh_aw_done", {a_awvalid, a_wvalid, a_bready, a_out_valid}, 4'b0010);
        bvalid = 1'b1; bresp = OKAY; out_ready = 1'b1;
        @(negedge clk);
        bvalid = 1'b0;
        chk("sh_done", {a_out_valid, a_bready, a_out_err, a_code, a_out_rdata}, {1'b1, 1'b0, 1'b0, 2'b00, 32'h0});
        @(negedge clk);
        chk("sh_single", a_out_valid, 0);

        // misaligned LW: fault at T+1, no read issued
        issue(1'b1, 1'b0, LW, 32'h8000_0001, 32'h0);
        chk("lw_mis", {a_out_valid, a_out_err, a_code, a_arvalid}, {1'b1, 1'b1, ERR_MISALIGN, 1'b0});
        @(negedge clk);
        chk("lw_mis_noar", {a_arvalid, a_out_valid, a_in_ready}, 3'b001);

        // funct3 110 is illegal at DATA_W=32
        issue(1'b1, 1'b0, LWU, 32'h8000_0004, 32'h0);
        chk("lwu32_illegal", {a_out_valid, a_out_err, a_code, a_arvalid}, {1'b1, 1'b1, ERR_SIZE, 1'b0});
        @(negedge clk);

        // non-memory op passes straight through
        issue(1'b0, 1'b0, LW, 32'h8000_0000, 32'h0);
        chk("nonmem", {a_out_valid, a_out_err, a_code, a_out_rdata, a_arvalid, a_awvalid}, {1'b1, 1'b0, 2'b00, 32'h0, 2'b00});
        @(negedge clk);

        // SW with SLVERR, AW and W in the same cycle
        issue(1'b0, 1'b1, SW, 32'h8000_0010, 32'h1234_5678);
        chk("sw_wdata_strb", {a_wdata, a_wstrb}, {32'h1234_5678, 4'hF});
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        chk("sw_both", {a_awvalid, a_wvalid, a_bready}, 3'b001);
        bvalid = 1'b1; bresp = 2'b10;
        @(negedge clk);
        bvalid = 1'b0;
        chk("sw_slverr_a", {a_out_valid, a_out_err, a_code}, {1'b1, 1'b1, ERR_BUS});
        chk("sw_slverr_b", {b_out_valid, b_out_err, b_code}, {1'b1, 1'b1, ERR_BUS});
        @(negedge clk);

        // SW with EXOKAY: rejected only when OKAY_ONLY=1
        issue(1'b0, 1'b1, SW, 32'h8000_0010, 32'h1234_5678);
        awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        bvalid = 1'b1; bresp = EXOKAY;
        @(negedge clk);
        bvalid = 1'b0;
        chk("sw_exokay_a", {a_out_valid, a_out_err, a_code}, {1'b1, 1'b1, ERR_BUS});
        chk("sw_exokay_b", {b_out_valid, b_out_err, b_code}, {1'b1, 1'b0, ERR_NONE});
        @(negedge clk);
        out_ready = 1'b0;

        // async reset while waiting in RD_DATA
        issue(1'b1, 1'b0, LW, 32'h8000_0020, 32'h0);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rst_pre_rready", a_rready, 1);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", {a_arvalid, a_rready, a_awvalid, a_wvalid, a_bready, a_out_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release", {a_in_ready, a_rready, a_out_valid}, 3'b100);

        // 64-bit: LWU and LW from the upper word
        d_out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            d_in_valid = 1'b1; d_in_load = 1'b1; d_funct3 = (k == 0) ? LWU : LW; d_addr = 32'h0000_1004;
            @(negedge clk);
            d_in_valid = 1'b0; d_in_load = 1'b0;
            chk("d_ar", {d_arvalid, d_araddr}, {1'b1, 32'h0000_1004});
            d_arready = 1'b1;
            @(negedge clk);
            d_arready = 1'b0;
            d_rvalid = 1'b1; d_rdata = 64'hF000_0001_0000_0000;
            @(negedge clk);
            d_rvalid = 1'b0;
            chk("d_out", {d_out_valid, d_out_err}, 2'b10);
            chk((k == 0) ? "d_lwu_rdata" : "d_lw_rdata", d_out_rdata,
                (k == 0) ? 64'h0000_0000_F000_0001 : 64'hFFFF_FFFF_F000_0001);
            @(negedge clk);
        end

        // 64-bit SW into the upper lanes
        d_in_valid = 1'b1; d_in_store = 1'b1; d_funct3 = SW; d_addr = 32'h0000_1004;
        d_in_wdata = 64'h0000_0000_CAFE_BABE;
        @(negedge clk);
        d_in_valid = 1'b0; d_in_store = 1'b0;
        chk("d_sw_lanes", {d_wdata, d_wstrb}, {64'hCAFE_BABE_0000_0000, 8'hF0});
        d_awready = 1'b1; d_wready = 1'b1;
        @(negedge clk);
        d_awready = 1'b0; d_wready = 1'b0;
        d_bvalid = 1'b1; d_bresp = OKAY;
        @(negedge clk);
        d_bvalid = 1'b0;
        chk("d_sw_done", {d_out_valid, d_out_err, d_code}, {1'b1, 1'b0, 2'b00});
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lsu_axil_fsm.md
Name: lsu_axil_fsm

Overview:
- Parametrised load/store unit: takes one decoded memory op per upstream valid/ready handshake and runs it as a single AXI-lite master transaction.
- Returns aligned, sign/zero-extended load data and error status downstream.
- Sits between EX and WB in the 5-stage SoC core, with its master port on the crossbar.
- Adds over the previous LSU:
  - registered, stable AXI signals;
  - independent AW/W handshakes;
  - response (resp) error checking;
  - misalignment trapping;
  - 64-bit data support.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 32, datapath and AXI data width; legal values are 32 and 64 only.
- OKAY_ONLY, 1, when 1, any resp other than 2'b00 flags out_err; when 0, EXOKAY (2'b01) is also accepted.

Ports:
- clk in 1: clock.
- rst_n in 1: reset, asynchronous, active-low.
- in_valid in 1: upstream op valid.
- in_ready out 1: LSU can accept an op.
- in_load in 1: op is a load.
- in_store in 1: op is a store (never set together with in_load).
- in_funct3 in 3: RISC-V load/store funct3.
- in_addr in ADDR_W: effective address.
- in_wdata in DATA_W: store data, LSB-aligned.
- out_valid out 1: result valid.
- out_ready in 1: downstream accepts the result.
- out_rdata out DATA_W: extended load data; 0 for stores and non-memory ops.
- out_err out 1: op faulted.
- out_err_code out 2: 0 = none, 1 = misaligned, 2 = bus error, 3 = illegal size.
- AXI-lite master, all widths per the parameters: araddr, arvalid, arready, rdata, rresp, rvalid, rready, awaddr, awvalid, awready, wdata, wstrb (DATA_W/8 bits), wvalid, wready, bresp, bvalid, bready.

Behaviour:
- Reset (rst_n low, async): state = IDLE.
  - All valids/readys driven by the LSU are 0: arvalid, awvalid, wvalid, rready, bready, out_valid.
  - out_rdata, out_err and out_err_code are 0.
  - in_ready is 1 once reset is released.
  - Reset mid-transaction abandons it; reset is system-wide, so the slave is reset too.
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- in_ready = (state == IDLE). An op is accepted on in_valid & in_ready, and all inputs are latched at that edge.
- Decode at accept:
  - Illegal size: funct3 011 or 110 with DATA_W = 32, or any other undefined code. Go to DONE with code 3 and no bus access.
  - Misaligned: half on an odd address, word with addr[1:0] != 0, or dword with addr[2:0] != 0. Go to DONE with code 1 and no bus access.
  - Load: go to RD_ADDR.
  - Store: go to WR_REQ.
  - Neither in_load nor in_store: go to DONE with no error.
- RD_ADDR:
  - Drive arvalid = 1 and araddr = latched address (full address; the slave ignores low bits).
  - Stay in RD_ADDR until arready, then go to RD_DATA.
- RD_DATA:
  - Drive rready = 1.
  - On rvalid: capture the extended data and the resp check, then go to DONE.
- WR_REQ:
  - Drive awvalid and wvalid together.
  - awvalid drops independently after its handshake; wvalid drops independently after its handshake.
  - If both handshakes happen in the same cycle, leave directly.
  - Go to WR_RESP once both handshakes are done, in whatever order they occur.
- WR_RESP:
  - Drive bready = 1.
  - On bvalid: capture the resp check, then go to DONE.
- DONE:
  - Drive out_valid = 1, with outputs held stable.
  - On out_ready, go to IDLE.
- All AXI outputs are registered. None depends combinationally on AXI inputs or on out_ready.
- Alignment, with off = addr[log2(DATA_W/8)-1:0]:
  - Loads: shift rdata right by off*8, then sign- or zero-extend per funct3.
  - Stores: wdata = in_wdata << off*8; wstrb = size mask << off.
- Latency with zero-wait slave: load accepted at T gives arvalid at T+1, rvalid at T+2, out_valid at T+3.
- Store accepted at T gives aw/w handshake at T+1, bvalid at T+2, out_valid at T+3.
- Faults: out_valid at T+1.

Decomposition:
- Package lsu_pkg holds:
  - lsu_state_e;
  - err code constants;
  - funct3 constants LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD;
  - AXI resp constants OKAY and EXOKAY.
- One sub-module, lsu_align: purely combinational. It performs size decode, misalignment/illegal checks, load shift and extend, and store shift and wstrb generation.
- The FSM stays in lsu_axil_fsm.

Test Plan:
- LB, addr 0x8000_0003, slave rdata 0x80FF_1234 → out_rdata 0xFFFF_FF80, out_err 0, out_valid exactly 3 cycles after accept.
- SH, addr 0x8000_0002, wdata 0x0000_ABCD → wdata 0xABCD_0000, wstrb 4'b1100. Slave accepts W 2 cycles before AW → wvalid drops after its handshake, awvalid holds until accepted, single out_valid.
- LW, addr 0x8000_0001 → out_err 1, code 1, out_valid at T+1, arvalid never asserted.
- SW with bresp 2'b10 (SLVERR) → out_err 1, code 2. Repeat with OKAY_ONLY = 0 and bresp 2'b01 → out_err 0.
- DATA_W = 64, LWU at 0x…4, rdata 0xF000_0001_0000_0000 → out_rdata 0x0000_0000_F000_0001. With DATA_W = 32, funct3 110 → code 3.
- Backpressure and reset:
  - Hold out_ready = 0 for 5 cycles in DONE → outputs stable, in_ready 0.
  - Assert rst_n = 0 during RD_DATA → all valids 0 immediately (async), in_ready 1 after release.
